// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: round-robin burst scheduler that drains N FWFT FIFOs
// into one registered valid/ready output, granting one FIFO per burst.
// Optional feature macro: FIFO_RR_SCHED_WEIGHT_EN adds a burst_len input
// giving each source its own burst limit (0 masks the source).
module fifo_rr_scheduler #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4,
    parameter int SW        = $clog2(N),
    parameter int CW        = $clog2(MAX_BURST) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    fifo_empty,
    input  logic [N*DW-1:0] fifo_dout,
    output logic [N-1:0]    fifo_rd_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [SW-1:0]   out_src
`ifdef FIFO_RR_SCHED_WEIGHT_EN
    ,
    input  logic [N*CW-1:0] burst_len
`endif
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state, state_next;
    logic [SW-1:0] grant, grant_next;
    logic [SW-1:0] ptr, ptr_next;
    logic [CW-1:0] burst_cnt, burst_cnt_next;
    logic [CW-1:0] last_cnt;
    logic [SW-1:0] sel;
    logic [SW-1:0] grant_inc;
    logic          found;
    logic          load;
    logic          pop;
    logic [N-1:0]  eligible;
    logic          out_valid_next;
    logic [DW-1:0] out_data_next;
    logic [SW-1:0] out_src_next;
`ifdef FIFO_RR_SCHED_WEIGHT_EN
    logic [CW-1:0] limit, limit_next;
    logic [CW-1:0] sel_limit;
`endif

    // Index addition modulo N, so non-power-of-two N never yields an index >= N.
    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return SW'(s);
    endfunction

    // A source may be granted only when it has data (and, when weighted, a nonzero limit).
    always_comb begin
        eligible = ~fifo_empty;
`ifdef FIFO_RR_SCHED_WEIGHT_EN
        for (int i = 0; i < N; i++) begin
            if (burst_len[i*CW +: CW] == '0) eligible[i] = 1'b0;
        end
`endif
    end

    // Round-robin scan starting at ptr: pick the first eligible source.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && eligible[wrap_add(ptr, k)]) begin
                found = 1'b1;
                sel   = wrap_add(ptr, k);
            end
        end
    end

`ifdef FIFO_RR_SCHED_WEIGHT_EN
    // Per-source limit of the selected source, clamped to MAX_BURST.
    always_comb begin
        sel_limit = burst_len[int'(sel)*CW +: CW];
        if (sel_limit > CW'(MAX_BURST)) sel_limit = CW'(MAX_BURST);
    end
`endif

    // Pop strobe: only the granted FIFO, only when it has data and the output can take it.
    always_comb begin
        load      = !out_valid || out_ready;
        pop       = (state == BURST) && !fifo_empty[grant] && load;
        grant_inc = wrap_add(grant, 1);
`ifdef FIFO_RR_SCHED_WEIGHT_EN
        last_cnt  = limit - CW'(1);
`else
        last_cnt  = CW'(MAX_BURST - 1);
`endif
        fifo_rd_en = '0;
        if (pop) fifo_rd_en[grant] = 1'b1;
    end

    // Next-state logic for the arbiter FSM, burst counter and output register.
    always_comb begin
        state_next     = state;
        grant_next     = grant;
        ptr_next       = ptr;
        burst_cnt_next = burst_cnt;
        out_valid_next = out_valid;
        out_data_next  = out_data;
        out_src_next   = out_src;
`ifdef FIFO_RR_SCHED_WEIGHT_EN
        limit_next     = limit;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    grant_next     = sel;
                    burst_cnt_next = '0;
                    state_next     = BURST;
`ifdef FIFO_RR_SCHED_WEIGHT_EN
                    limit_next     = sel_limit;
`endif
                end
            end
            BURST: begin
                if (fifo_empty[grant]) begin
                    state_next = IDLE;
                    ptr_next   = grant_inc;
                end else if (pop && (burst_cnt == last_cnt)) begin
                    state_next = IDLE;
                    ptr_next   = grant_inc;
                end
            end
            default: state_next = IDLE;
        endcase
        if (pop) begin
            out_data_next  = fifo_dout[int'(grant)*DW +: DW];
            out_src_next   = grant;
            out_valid_next = 1'b1;
            burst_cnt_next = burst_cnt + CW'(1);
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    // State and output registers; reset aborts any burst and drops the held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
`ifdef FIFO_RR_SCHED_WEIGHT_EN
            limit     <= '0;
`endif
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            ptr       <= ptr_next;
            burst_cnt <= burst_cnt_next;
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
            out_src   <= out_src_next;
`ifdef FIFO_RR_SCHED_WEIGHT_EN
            limit     <= limit_next;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb_fifo_rr_scheduler: scoreboard bench for fifo_rr_scheduler with a
// behavioural FWFT FIFO bank. Define FIFO_RR_SCHED_WEIGHT_EN to also
// exercise the per-source burst limits.
module tb_fifo_rr_scheduler;

    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;
    localparam int SW        = $clog2(N);
    localparam int CW        = $clog2(MAX_BURST) + 1;
    localparam int DEPTH     = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    fifo_empty;
    logic [N*DW-1:0] fifo_dout;
    logic [N-1:0]    fifo_rd_en;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
`ifdef FIFO_RR_SCHED_WEIGHT_EN
    logic [N*CW-1:0] burst_len;
`endif

    typedef struct {
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        int            cyc;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] mem [N][DEPTH];
    int            head [N];
    int            tail [N];
    int            cyc;
    int            tests = 0;
    int            fails = 0;

    fifo_rr_scheduler #(.N(N), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src)
`ifdef FIFO_RR_SCHED_WEIGHT_EN
        ,
        .burst_len  (burst_len)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard time limit so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [DW-1:0] word(input int s, input int k);
        return DW'((s << 5) | k);
    endfunction

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = (head[i] == tail[i]);
            fifo_dout[i*DW +: DW] = (head[i] == tail[i]) ? '0 : mem[i][head[i] % DEPTH];
        end
    endtask

    task automatic push_word(input int s, input logic [DW-1:0] d);
        mem[s][tail[s] % DEPTH] = d;
        tail[s] = tail[s] + 1;
    endtask

    task automatic expect_beat(input int s, input logic [DW-1:0] d, input int c);
        beat_t b;
        b.src  = SW'(s);
        b.data = d;
        b.cyc  = c;
        exp_q.push_back(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        exp_q.delete();
        refresh();
        @(negedge clk);
    endtask

    task automatic release_reset();
        refresh();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    // One clock cycle: drive out_ready at the falling edge, observe the
    // settled outputs, then retire any popped word after the rising edge.
    task automatic step(input logic rdy, output logic acc, output logic [SW-1:0] src,
                        output logic [DW-1:0] data, output logic [N-1:0] rd,
                        output logic vld, output int ocyc);
        out_ready = rdy;
        #1;
        vld  = out_valid;
        acc  = out_valid && rdy;
        src  = out_src;
        data = out_data;
        rd   = fifo_rd_en;
        ocyc = cyc;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rd[i] && (head[i] != tail[i])) head[i] = head[i] + 1;
        end
        refresh();
        @(negedge clk);
        cyc = cyc + 1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < N; i++) push_word(i, word(i, 0));
        refresh();
        @(posedge clk);
        #1;
        tests++;
        if (fifo_rd_en !== '0) begin
            fails++;
            $display("[TB] FAIL reset_rd_en: got %b, expected 0", fifo_rd_en);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid);
        end
        tests++;
        if (out_data !== '0) begin
            fails++;
            $display("[TB] FAIL reset_out_data: got %h, expected 0", out_data);
        end
        tests++;
        if (out_src !== '0) begin
            fails++;
            $display("[TB] FAIL reset_out_src: got %0d, expected 0", out_src);
        end
    endtask

    task automatic test_single_source();
        logic acc, vld;
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        logic [N-1:0] rd;
        int ocyc;
        beat_t e;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            push_word(0, word(0, k));
            expect_beat(0, word(0, k), 2 + k + k / 4);
        end
        release_reset();
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            step(1'b1, acc, src, data, rd, vld, ocyc);
            if (acc) begin
                e = exp_q.pop_front();
                tests++;
                if (src !== e.src || data !== e.data || ocyc != e.cyc) begin
                    fails++;
                    $display("[TB] FAIL single_source beat: got src=%0d data=%h cyc=%0d, expected src=%0d data=%h cyc=%0d",
                             src, data, ocyc, e.src, e.data, e.cyc);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL single_source timeout: %0d beats missing, expected 0", exp_q.size());
        end
        for (int c = 0; c < 4; c++) begin
            step(1'b1, acc, src, data, rd, vld, ocyc);
            tests++;
            if (acc !== 1'b0) begin
                fails++;
                $display("[TB] FAIL single_source extra beat: got data=%h, expected no beat", data);
            end
        end
    endtask

    task automatic test_all_sources();
        logic acc, vld;
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        logic [N-1:0] rd;
        int ocyc;
        beat_t e;
        do_reset();
        for (int s = 0; s < N; s++) begin
            for (int k = 0; k < 8; k++) push_word(s, word(s, k));
        end
        for (int g = 0; g < 8; g++) begin
            for (int w = 0; w < 4; w++) expect_beat(g % 4, word(g % 4, (g / 4) * 4 + w), 2 + 5 * g + w);
        end
        release_reset();
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            step(1'b1, acc, src, data, rd, vld, ocyc);
            if (acc) begin
                e = exp_q.pop_front();
                tests++;
                if (src !== e.src || data !== e.data || ocyc != e.cyc) begin
                    fails++;
                    $display("[TB] FAIL all_sources beat: got src=%0d data=%h cyc=%0d, expected src=%0d data=%h cyc=%0d",
                             src, data, ocyc, e.src, e.data, e.cyc);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL all_sources timeout: %0d beats missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic acc, vld, rdy, prev_hold;
        logic [SW-1:0] src, prev_src;
        logic [DW-1:0] data, prev_data;
        logic [N-1:0] rd;
        int ocyc;
        beat_t e;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            push_word(2, word(2, k));
            expect_beat(2, word(2, k), -1);
        end
        release_reset();
        prev_hold = 1'b0;
        prev_src  = '0;
        prev_data = '0;
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            rdy = (c % 4 == 0) || (c % 4 == 3);
            step(rdy, acc, src, data, rd, vld, ocyc);
            if (prev_hold) begin
                tests++;
                if (vld !== 1'b1 || data !== prev_data || src !== prev_src) begin
                    fails++;
                    $display("[TB] FAIL backpressure_hold: got valid=%b data=%h src=%0d, expected valid=1 data=%h src=%0d",
                             vld, data, src, prev_data, prev_src);
                end
            end
            if (vld && !rdy) begin
                tests++;
                if (rd !== '0) begin
                    fails++;
                    $display("[TB] FAIL backpressure_rd_en: got %b, expected 0", rd);
                end
            end
            if (acc) begin
                e = exp_q.pop_front();
                tests++;
                if (src !== e.src || data !== e.data) begin
                    fails++;
                    $display("[TB] FAIL backpressure beat: got src=%0d data=%h, expected src=%0d data=%h",
                             src, data, e.src, e.data);
                end
            end
            prev_hold = vld && !rdy;
            prev_data = data;
            prev_src  = src;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL backpressure timeout: %0d beats missing, expected 0", exp_q.size());
        end
        for (int c = 0; c < 4; c++) begin
            step(1'b1, acc, src, data, rd, vld, ocyc);
            tests++;
            if (acc !== 1'b0) begin
                fails++;
                $display("[TB] FAIL backpressure duplicate: got data=%h, expected no beat", data);
            end
        end
    endtask

    task automatic test_run_dry();
        logic acc, vld;
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        logic [N-1:0] rd;
        int ocyc;
        int exp_cycles [7];
        beat_t e;
        exp_cycles = '{2, 3, 6, 7, 8, 9, 11};
        do_reset();
        for (int k = 0; k < 2; k++) begin
            push_word(1, word(1, k));
            expect_beat(1, word(1, k), exp_cycles[k]);
        end
        for (int k = 0; k < 5; k++) begin
            push_word(3, word(3, k));
            expect_beat(3, word(3, k), exp_cycles[2 + k]);
        end
        release_reset();
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            step(1'b1, acc, src, data, rd, vld, ocyc);
            if (acc) begin
                e = exp_q.pop_front();
                tests++;
                if (src !== e.src || data !== e.data || ocyc != e.cyc) begin
                    fails++;
                    $display("[TB] FAIL run_dry beat: got src=%0d data=%h cyc=%0d, expected src=%0d data=%h cyc=%0d",
                             src, data, ocyc, e.src, e.data, e.cyc);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL run_dry timeout: %0d beats missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        logic acc, vld;
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        logic [N-1:0] rd;
        int ocyc;
        beat_t e;
        do_reset();
        push_word(0, word(0, 0));
        push_word(0, word(0, 1));
        expect_beat(0, word(0, 0), 2);
        expect_beat(0, word(0, 1), 3);
        for (int k = 0; k < 6; k++) push_word(3, word(3, k));
        expect_beat(3, word(3, 0), 6);
        release_reset();
        for (int c = 0; c < 7; c++) begin
            step(1'b1, acc, src, data, rd, vld, ocyc);
            if (acc) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL reset_prefix beat: got src=%0d data=%h, expected no beat", src, data);
                end else begin
                    e = exp_q.pop_front();
                    if (src !== e.src || data !== e.data || ocyc != e.cyc) begin
                        fails++;
                        $display("[TB] FAIL reset_prefix beat: got src=%0d data=%h cyc=%0d, expected src=%0d data=%h cyc=%0d",
                                 src, data, ocyc, e.src, e.data, e.cyc);
                    end
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL reset_prefix count: %0d beats missing, expected 0", exp_q.size());
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (fifo_rd_en !== 4'b1000) begin
            fails++;
            $display("[TB] FAIL reset_third_beat rd_en: got %b, expected 1000", fifo_rd_en);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || fifo_rd_en !== '0) begin
            fails++;
            $display("[TB] FAIL reset_async: got valid=%b rd_en=%b, expected valid=0 rd_en=0", out_valid, fifo_rd_en);
        end
        tests++;
        if (out_data !== '0 || out_src !== '0) begin
            fails++;
            $display("[TB] FAIL reset_async_data: got data=%h src=%0d, expected data=0 src=0", out_data, out_src);
        end
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            push_word(0, word(0, 8 + k));
            expect_beat(0, word(0, 8 + k), 2 + k);
        end
        release_reset();
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            step(1'b1, acc, src, data, rd, vld, ocyc);
            if (acc) begin
                e = exp_q.pop_front();
                tests++;
                if (src !== e.src || data !== e.data || ocyc != e.cyc) begin
                    fails++;
                    $display("[TB] FAIL reset_restart beat: got src=%0d data=%h cyc=%0d, expected src=%0d data=%h cyc=%0d",
                             src, data, ocyc, e.src, e.data, e.cyc);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL reset_restart timeout: %0d beats missing, expected 0", exp_q.size());
        end
    endtask

`ifdef FIFO_RR_SCHED_WEIGHT_EN
    task automatic test_weighted();
        logic acc, vld;
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        logic [N-1:0] rd;
        int ocyc;
        beat_t e;
        do_reset();
        burst_len = {CW'(0), CW'(1), CW'(2), CW'(4)};
        for (int s = 0; s < N; s++) begin
            for (int k = 0; k < 16; k++) push_word(s, word(s, k));
        end
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 4; w++) expect_beat(0, word(0, r * 4 + w), -1);
            for (int w = 0; w < 2; w++) expect_beat(1, word(1, r * 2 + w), -1);
            expect_beat(2, word(2, r), -1);
        end
        release_reset();
        for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
            step(1'b1, acc, src, data, rd, vld, ocyc);
            if (acc) begin
                e = exp_q.pop_front();
                tests++;
                if (src !== e.src || data !== e.data) begin
                    fails++;
                    $display("[TB] FAIL weighted beat: got src=%0d data=%h, expected src=%0d data=%h",
                             src, data, e.src, e.data);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL weighted timeout: %0d beats missing, expected 0", exp_q.size());
        end
        burst_len = {N{CW'(MAX_BURST)}};
    endtask
`endif

    // Test sequence.
    initial begin
        out_ready = 1'b1;
        fifo_empty = '1;
        fifo_dout = '0;
`ifdef FIFO_RR_SCHED_WEIGHT_EN
        burst_len = {N{CW'(MAX_BURST)}};
`endif
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        cyc = 0;
        test_reset();
        test_single_source();
        test_all_sources();
        test_backpressure();
        test_run_dry();
        test_reset_mid_burst();
`ifdef FIFO_RR_SCHED_WEIGHT_EN
        test_weighted();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_rr_scheduler.md
# fifo_rr_scheduler

- Round-robin burst scheduler that shares one downstream valid/ready sink between N first-word-fall-through (FWFT) FIFOs.
- Each FIFO exposes the `rd_en`/`dout`/`empty` read side.
- The scheduler grants one FIFO at a time and pops up to a bounded burst of words from it into a registered output stage, then rotates.
- It sits between a bank of per-channel sync FWFT FIFOs and a single shared consumer, such as a DMA write port or a serializer.

## Interface
- `N`, 4: number of requester FIFOs; must be ≥ 2.
- `DW`, 8: data width of each FIFO and of the output.
- `MAX_BURST`, 4: maximum words popped per grant; must be ≥ 1.
- Derived widths: `SW` = clog2(`N`), `CW` = clog2(`MAX_BURST`)+1.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  N  per-FIFO empty flag, from the FWFT FIFO.
- `fifo_dout`  in  N*DW  per-FIFO head word; slice i is bits [i*DW +: DW]; valid whenever `fifo_empty[i]`=0.
- `fifo_rd_en`  out  N  per-FIFO pop strobe; one-hot or zero.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  downstream accepts the word this cycle.
- `out_data`  out  DW  output word.
- `out_src`  out  SW  index of the FIFO that supplied `out_data`.

## Operation
- State machine states: IDLE and BURST. Registers: `state`, `grant`[SW], `ptr`[SW], `burst_cnt`[CW], and the output register.
- Reset values (asynchronous): `state`=IDLE, `grant`=0, `ptr`=0, `burst_cnt`=0, `out_valid`=0, `out_data`=0, `out_src`=0. `fifo_rd_en` is 0 while `rst`=1.
- IDLE:
  - If any `fifo_empty[i]`=0, select the first non-empty index scanning `ptr`, `ptr`+1, … modulo N.
  - Then: `grant`<=that index, `burst_cnt`<=0, `state`<=BURST.
  - Otherwise remain in IDLE.
- `load` = `!out_valid || out_ready`.
- Pop rule (combinational from registers and inputs): `fifo_rd_en[grant]` = (`state`==BURST) && `!fifo_empty[grant]` && `load`. All other bits are 0.
- On a pop: `out_data`<=slice `grant` of `fifo_dout`, `out_src`<=`grant`, `out_valid`<=1, `burst_cnt`<=`burst_cnt`+1.
- When there is no pop and `out_ready`=1: `out_valid`<=0, and `out_data`/`out_src` hold.
- BURST exit conditions, which go to IDLE with `ptr`<=(`grant`+1) mod N:
  - (a) a pop while `burst_cnt`==`MAX_BURST`-1;
  - (b) `fifo_empty[grant]`=1 in BURST, meaning the FIFO ran dry.
- Backpressure (`load`=0) in BURST does not end the burst. The grant is held indefinitely.
- Fairness: a continuously non-empty FIFO waits at most (N-1) bursts between its grants.
- `ptr` wraps from N-1 to 0. When N is not a power of two, the index arithmetic is modulo N and never produces an index ≥ N.
- Mid-operation `rst` aborts any burst immediately and discards an undelivered `out_data`.

## Timing
- Arbitration costs one bubble cycle: IDLE → BURST takes 1 cycle with no pop.
- In BURST with `out_ready`=1 and the FIFO non-empty, the block sustains one pop per cycle.
- Latency from a pop to `out_valid`=1 with the same word: 1 cycle.
- Peak throughput is `MAX_BURST`/(`MAX_BURST`+1) words per cycle under full load.
- `out_valid` stays high and `out_data`/`out_src` stay stable until a cycle with `out_ready`=1.
- Pop and accept in the same cycle are legal and keep `out_valid`=1.
- `fifo_empty[grant]` rising in the same cycle as a would-be pop: no pop occurs, and exit (b) applies.

## Configuration
- Macro: `FIFO_RR_SCHED_WEIGHT_EN`.
- Without the macro: every grant uses the burst limit `MAX_BURST`.
- With the macro:
  - An extra input `burst_len` (N*CW) supplies a per-source limit. It is sampled into a `limit` register at the IDLE→BURST transition.
  - Exit (a) uses `limit`-1 instead of `MAX_BURST`-1.
  - Values above `MAX_BURST` clamp to `MAX_BURST`.
  - A value of 0 masks that source: it is skipped in the IDLE scan as if it were empty.
  - Changes to `burst_len` during BURST take effect at the next grant.

## Test plan
- N=4, MAX_BURST=4. FIFO0 holds 10 words and the others are empty, `out_ready`=1. Required response:
  - bursts of 4, 4, 2 words, each preceded by 1 bubble cycle;
  - `out_src`=0 throughout;
  - data in order.
- All 4 FIFOs hold 8 words each, `out_ready`=1. Required response:
  - grant order is 0,1,2,3,0,1,2,3;
  - 4 words per grant;
  - 32 words total in 40 cycles after the first grant.
- FIFO2 only, `out_ready` toggles 1,0,0,1 repeatedly. Required response:
  - `out_data` holds stable while `out_ready`=0;
  - no `fifo_rd_en` while `out_valid`=1 and `out_ready`=0;
  - no word is lost or duplicated.
- FIFO1 holds 2 words and FIFO3 holds 5 words. Required response:
  - FIFO1 runs dry after 2 pops and the burst exits;
  - the next grant is FIFO3 with `ptr`=2;
  - `out_src` sequence is 1,1,3,3,3,3, then 3 after re-arbitration.
- Assert `rst` asynchronously during the 3rd beat of a burst. Required response:
  - `out_valid`=0 and `fifo_rd_en`=0 within the same cycle;
  - after release, arbitration starts from index 0.
- With `FIFO_RR_SCHED_WEIGHT_EN` and `burst_len`={0,1,2,4} (sources 3..0), all FIFOs full. Required response:
  - source 3 is never granted;
  - bursts are 4, 2, 1 words for sources 0, 1, 2, repeating.
